// File: rtl/fetch_unit_pkg.sv
// Shared fetch/cache constants and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned DATA_WIDTH = 39;
    localparam int unsigned ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: synchronous reset, load-target and modulo increment.
module fetch_pc #(
    parameter int unsigned ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_pc_i,
    input  logic                  inc_en_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Load wins over increment; increment wraps naturally at the address width.
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_pc_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= ADDR_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and valid/ready handoff to decode,
// with branch redirect/flush and a sticky halt.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH = fetch_unit_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  halted
);

    import fetch_unit_pkg::*;

    fetch_state_e          state_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0] ir_pc_q;
    logic                  ir_valid_q;
    logic                  halted_q;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_load;
    logic                  pc_inc;

    // RUN-state priority: halt, then redirect, then load when the IR slot is free.
    assign pc_load = (state_q == ST_RUN) && !halt && redirect;
    assign pc_inc  = (state_q == ST_RUN) && !halt && !redirect && (!ir_valid_q || ir_ready);

    fetch_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .load_en_i (pc_load),
        .load_pc_i (redirect_pc),
        .inc_en_i  (pc_inc),
        .pc_o      (pc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ir_valid_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q    <= ST_HALT;
                        ir_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (redirect) begin
                        ir_valid_q <= 1'b0;
                    end else if (pc_inc) begin
                        ir_q       <= Instruction;
                        ir_pc_q    <= pc;
                        ir_valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    ir_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign addr     = pc;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule
